// File: rtl/sc_bitstream_gen.sv
// Stochastic number generator: compares LFSR words against a latched value to emit a unipolar bitstream.
// Optional SC_ONES_COUNT_EN adds a ones_count output tallying the accepted 1-bits of the current stream.
module sc_bitstream_gen #(
  parameter int unsigned N     = 8,
  parameter int unsigned LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_value,
  input  logic [LEN_W-1:0] in_len,
  input  logic [N-1:0]     rnd,
  output logic             lfsr_enable,
  output logic             lfsr_restart,
  output logic             bit_out,
  output logic             bit_valid,
  input  logic             bit_ready,
  output logic             last,
`ifdef SC_ONES_COUNT_EN
  output logic [LEN_W-1:0] ones_count,
`endif
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEED   = 2'd1,
    STREAM = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [N-1:0]     value_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] cnt;
  logic             req_take;
  logic             bit_take;

  // State register and datapath; in_len==0 requests are accepted but never latched.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      value_q <= '0;
      len_q   <= '0;
      cnt     <= '0;
    end else begin
      state <= state_nxt;
      if (req_take && (in_len != '0)) begin
        value_q <= in_value;
        len_q   <= in_len;
        cnt     <= '0;
      end else if (bit_take) begin
        cnt <= cnt + LEN_W'(1);
      end
    end
  end

  // Next state and handshake outputs; bit_out/last/lfsr_enable follow rnd and bit_ready directly.
  always_comb begin
    state_nxt    = state;
    in_ready     = 1'b0;
    busy         = 1'b1;
    lfsr_restart = 1'b0;
    lfsr_enable  = 1'b0;
    bit_valid    = 1'b0;
    bit_out      = 1'b0;
    last         = 1'b0;
    req_take     = 1'b0;
    bit_take     = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        req_take = in_valid;
        if (in_valid && (in_len != '0)) state_nxt = SEED;
      end
      SEED: begin
        lfsr_restart = 1'b1;
        state_nxt    = STREAM;
      end
      STREAM: begin
        bit_valid   = 1'b1;
        bit_out     = (rnd < value_q);
        last        = (cnt == (len_q - LEN_W'(1)));
        bit_take    = bit_ready;
        lfsr_enable = bit_ready;
        if (bit_ready && last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef SC_ONES_COUNT_EN
  // Tally of accepted 1-bits, held through IDLE until the next accepted request.
  always_ff @(posedge clk) begin
    if (rst || req_take) begin
      ones_count <= '0;
    end else if (bit_take && bit_out) begin
      ones_count <= ones_count + LEN_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_sc_bitstream_gen.sv
// Directed self-checking bench for sc_bitstream_gen; bench drives rnd as the LFSR would.
module tb_sc_bitstream_gen;
  localparam int unsigned N     = 8;
  localparam int unsigned LEN_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     in_value;
  logic [LEN_W-1:0] in_len;
  logic [N-1:0]     rnd;
  logic             lfsr_enable;
  logic             lfsr_restart;
  logic             bit_out;
  logic             bit_valid;
  logic             bit_ready;
  logic             last;
  logic             busy;
`ifdef SC_ONES_COUNT_EN
  logic [LEN_W-1:0] ones_count;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  sc_bitstream_gen #(.N(N), .LEN_W(LEN_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_value     (in_value),
    .in_len       (in_len),
    .rnd          (rnd),
    .lfsr_enable  (lfsr_enable),
    .lfsr_restart (lfsr_restart),
    .bit_out      (bit_out),
    .bit_valid    (bit_valid),
    .bit_ready    (bit_ready),
    .last         (last),
`ifdef SC_ONES_COUNT_EN
    .ones_count   (ones_count),
`endif
    .busy         (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled around the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_idle(input string tag);
    #1;
    chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    chk({tag, ".bit_valid"}, 32'(bit_valid), 32'd0);
    chk({tag, ".busy"}, 32'(busy), 32'd0);
    chk({tag, ".restart"}, 32'(lfsr_restart), 32'd0);
    chk({tag, ".last"}, 32'(last), 32'd0);
  endtask

  // Present a request in IDLE, then check the one-cycle SEED phase.
  task automatic start_req(input string tag, input logic [N-1:0] v, input logic [LEN_W-1:0] l);
    in_valid = 1'b1;
    in_value = v;
    in_len   = l;
    #1;
    chk({tag, ".acc_ready"}, 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    #1;
    chk({tag, ".seed_restart"}, 32'(lfsr_restart), 32'd1);
    chk({tag, ".seed_enable"}, 32'(lfsr_enable), 32'd0);
    chk({tag, ".seed_valid"}, 32'(bit_valid), 32'd0);
    chk({tag, ".seed_ready"}, 32'(in_ready), 32'd0);
    chk({tag, ".seed_busy"}, 32'(busy), 32'd1);
    step();
  endtask

  // One accepted bit with the given random word.
  task automatic run_bit(input string tag, input logic [N-1:0] r, input logic eb, input logic el);
    rnd       = r;
    bit_ready = 1'b1;
    #1;
    chk({tag, ".valid"}, 32'(bit_valid), 32'd1);
    chk({tag, ".bit"}, 32'(bit_out), 32'(eb));
    chk({tag, ".last"}, 32'(last), 32'(el));
    chk({tag, ".enable"}, 32'(lfsr_enable), 32'd1);
    chk({tag, ".restart"}, 32'(lfsr_restart), 32'd0);
    step();
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_value  = '0;
    in_len    = '0;
    rnd       = '0;
    bit_ready = 1'b0;
    step();
    step();
    #1;
    chk("rst.in_ready", 32'(in_ready), 32'd1);
    chk("rst.bit_valid", 32'(bit_valid), 32'd0);
    chk("rst.bit_out", 32'(bit_out), 32'd0);
    chk("rst.last", 32'(last), 32'd0);
    chk("rst.enable", 32'(lfsr_enable), 32'd0);
    chk("rst.restart", 32'(lfsr_restart), 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    rst = 1'b0;
    step();
    chk_idle("post_rst");

    // Half probability, four bits.
    start_req("t1", 8'h80, 16'd4);
    run_bit("t1.b0", 8'h10, 1'b1, 1'b0);
    run_bit("t1.b1", 8'h90, 1'b0, 1'b0);
    run_bit("t1.b2", 8'h7F, 1'b1, 1'b0);
    run_bit("t1.b3", 8'h80, 1'b0, 1'b1);
    chk_idle("t1.end");
`ifdef SC_ONES_COUNT_EN
    chk("t1.ones", 32'(ones_count), 32'd2);
`endif

    // Extreme values.
    start_req("t2a", 8'h00, 16'd3);
    run_bit("t2a.b0", 8'h00, 1'b0, 1'b0);
    run_bit("t2a.b1", 8'h55, 1'b0, 1'b0);
    run_bit("t2a.b2", 8'hFF, 1'b0, 1'b1);
    chk_idle("t2a.end");
    start_req("t2b", 8'hFF, 16'd2);
    run_bit("t2b.b0", 8'hFF, 1'b0, 1'b0);
    run_bit("t2b.b1", 8'h00, 1'b1, 1'b1);
    chk_idle("t2b.end");

    // Backpressure after the second bit.
    start_req("t3", 8'h40, 16'd5);
    run_bit("t3.b0", 8'h10, 1'b1, 1'b0);
    run_bit("t3.b1", 8'h50, 1'b0, 1'b0);
    rnd       = 8'h30;
    bit_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("t3.stall_valid", 32'(bit_valid), 32'd1);
      chk("t3.stall_bit", 32'(bit_out), 32'd1);
      chk("t3.stall_last", 32'(last), 32'd0);
      chk("t3.stall_enable", 32'(lfsr_enable), 32'd0);
      chk("t3.stall_cnt", 32'(dut.cnt), 32'd2);
      step();
    end
    run_bit("t3.b2", 8'h30, 1'b1, 1'b0);
    run_bit("t3.b3", 8'h40, 1'b0, 1'b0);
    run_bit("t3.b4", 8'h3F, 1'b1, 1'b1);
    chk_idle("t3.end");

    // Zero-length request is dropped.
    in_valid = 1'b1;
    in_value = 8'hAA;
    in_len   = 16'd0;
    #1;
    chk("t4.ready", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    chk_idle("t4.drop0");
    chk("t4.enable", 32'(lfsr_enable), 32'd0);
    step();
    chk_idle("t4.drop1");
    start_req("t4", 8'h01, 16'd2);
    run_bit("t4.b0", 8'h00, 1'b1, 1'b0);
    run_bit("t4.b1", 8'h01, 1'b0, 1'b1);
    chk_idle("t4.end");

    // Reset in the middle of a stream.
    start_req("t5", 8'h80, 16'd6);
    run_bit("t5.b0", 8'h00, 1'b1, 1'b0);
    run_bit("t5.b1", 8'hFF, 1'b0, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_idle("t5.rst");
    chk("t5.enable", 32'(lfsr_enable), 32'd0);
    step();
    chk_idle("t5.after");

    // New request during STREAM is ignored.
    start_req("t6", 8'hC0, 16'd3);
    in_valid = 1'b1;
    in_value = 8'h10;
    in_len   = 16'd7;
    #1;
    chk("t6.ready_busy", 32'(in_ready), 32'd0);
    run_bit("t6.b0", 8'h80, 1'b1, 1'b0);
    run_bit("t6.b1", 8'hBF, 1'b1, 1'b0);
    run_bit("t6.b2", 8'hC0, 1'b0, 1'b1);
    in_valid = 1'b0;
    chk_idle("t6.end");
    step();
    chk_idle("t6.stay");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/sc_bitstream_gen.md
Name: sc_bitstream_gen

Overview:
Stochastic number generator (SNG) stage that sits directly downstream of the N-bit LFSR. It accepts a binary value and a stream length over a valid/ready handshake. It then compares the LFSR output against the value once per cycle and emits a unipolar stochastic bitstream of exactly that length. It also drives the LFSR's enable and restart inputs, so each stream starts from the LFSR seed and the LFSR only advances when a bit is consumed.

Parameters:
N, 8, width of the value and of the random word from the LFSR
LEN_W, 16, width of the stream-length field and of the internal bit counter

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
in_valid  input  1  request valid
in_ready  output  1  block can accept a request (high only in IDLE)
in_value  input  N  unsigned probability numerator, p = in_value / 2^N
in_len  input  LEN_W  number of bits to emit
rnd  input  N  random word, connected to the LFSR data output
lfsr_enable  output  1  advance the LFSR, connected to the LFSR enable
lfsr_restart  output  1  reload the LFSR seed, connected to the LFSR restart
bit_out  output  1  stochastic bit
bit_valid  output  1  bit_out valid
bit_ready  input  1  downstream accepts bit
last  output  1  current bit is the final bit of the stream
busy  output  1  stream in progress (state is not IDLE)

Behaviour:
- Reset: state=IDLE, value_q=0, len_q=0, cnt=0. in_ready=1. bit_valid, bit_out, last, lfsr_enable, lfsr_restart, busy all 0.
- FSM has three states: IDLE, SEED, STREAM.
- IDLE:
  - in_ready=1.
  - On in_valid with in_len!=0: latch value_q=in_value, len_q=in_len, cnt=0, and go to SEED.
  - On in_valid with in_len==0: the request is accepted and dropped. Stay in IDLE, no restart pulse, no bits.
- SEED:
  - Lasts exactly one cycle. lfsr_restart=1, lfsr_enable=0, in_ready=0, bit_valid=0.
  - Next state is STREAM. In the first STREAM cycle, rnd holds the LFSR seed.
- STREAM:
  - bit_valid=1.
  - bit_out = (rnd < value_q), an unsigned strict compare; combinational from rnd and value_q.
  - last = (cnt == len_q-1).
  - A bit is accepted when bit_valid && bit_ready.
  - lfsr_enable = bit_valid && bit_ready, so the LFSR advances exactly once per accepted bit.
  - On accept: cnt += 1. If last, go to IDLE; in_ready=1 in the following cycle.
- Backpressure: while bit_ready=0, the LFSR is held. rnd and therefore bit_out, last, and cnt stay stable.
- Latency: request accept to first bit_valid is 2 cycles (IDLE -> SEED -> STREAM).
- Boundary values:
  - value_q=0 gives all zeros.
  - value_q=2^N-1 gives 1 except when rnd==2^N-1.
  - len_q=2^LEN_W-1 is the maximum length; cnt never wraps.
- in_valid outside IDLE is ignored (in_ready=0); no queuing.
- rst mid-stream (SEED or STREAM) returns to IDLE with reset values on the next edge. The partially emitted stream is abandoned and no last is produced.
- lfsr_restart and lfsr_enable are never high in the same cycle.

Optional Feature:
Macro: SC_ONES_COUNT_EN
- When defined, adds output port ones_count [LEN_W-1:0].
  - Cleared to 0 on request accept and on rst.
  - Increments on each accepted bit with bit_out=1.
  - Holds its final value in IDLE until the next accepted request.
- When undefined, the port and its counter are absent; all other behaviour is identical.

Test Plan:
1. value=0x80, len=4, rnd driven 0x10,0x90,0x7F,0x80 on successive accepts, bit_ready=1 -> bits 1,0,1,0; lfsr_restart pulses one cycle before the first bit; last only on the 4th bit; in_ready=1 the cycle after; ones_count=2 if enabled.
2. value=0x00, len=3 -> bits 0,0,0; then value=0xFF, len=2, rnd=0xFF,0x00 -> bits 0,1.
3. value=0x40, len=5, bit_ready=0 for 2 cycles after the 2nd bit -> bit_out, last, and cnt stable; lfsr_enable=0 during the stall; total of exactly 5 accepted bits.
4. in_valid with len=0 -> in_ready stays 1; no lfsr_restart, no bit_valid; the next request with len=2 proceeds normally.
5. rst asserted during STREAM after 2 of 6 bits -> next cycle state IDLE, bit_valid=0, in_ready=1, last never asserted.
6. in_valid held high with a new value during STREAM -> in_ready=0 and the request is not latched; the active stream's value is unchanged until its last bit.
